mem_arbiter: RTL

Sequencer and arbiter for the single byte-wide memory bus (mem_din/mem_dout/mem_a/mem_wr) shared by the instruction cache and the data cache. It grants one requester at a time and splits each 1/2/4-byte access into byte beats, honouring the one-cycle read latency. It assembles read bytes little-endian into a word and stalls I/O writes while the UART buffer is full. It sits between icache/dcache and the cpu memory ports, replacing the ad-hoc mem_a/mem_wr muxing.

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Request/response signals of the icache and dcache ports plus
//                the shared byte-wide memory bus. The slave modport is the
//                arbiter's view; the master modport is the view of the
//                requesters and the memory/UART side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    // instruction fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_data;
    // data port
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    // byte-wide memory bus
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_done, if_data,
        input  d_req, d_wr, d_size, d_addr, d_wdata,
        output d_done, d_rdata,
        input  mem_din, io_buffer_full,
        output mem_dout, mem_a, mem_wr, busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_done, if_data,
        output d_req, d_wr, d_size, d_addr, d_wdata,
        input  d_done, d_rdata,
        output mem_din, io_buffer_full,
        input  mem_dout, mem_a, mem_wr, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbiter and byte-beat sequencer for the single byte-wide
//                memory bus shared by the instruction and data caches.
//                Splits 1/2/4-byte accesses into byte beats, assembles read
//                bytes little-endian and stalls I/O writes while the UART
//                buffer is full.
//  Options     : MEM_ARB_RR_EN - round-robin tie-break between data and
//                instruction requests (default: data always wins a tie).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter (
    input  wire          clk_in,
    input  wire          rst_in,
    input  wire          rdy_in,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RD   = 2'd1;
    localparam logic [1:0] C_WR   = 2'd2;
    localparam logic [1:0] C_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    logic [2:0]  r_cnt;        // beat counter k
    logic [2:0]  r_len;        // beats in this transaction (1/2/4)
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_is_data;    // granted transaction belongs to the data port
    logic        r_cap_en;     // a read byte is arriving on mem_din this cycle
    logic [1:0]  r_cap_lane;   // lane that byte belongs to
    logic [31:0] r_data;       // assembled read word

    logic        w_if_ok;
    logic        w_grant_d;
    logic        w_grant_i;
    logic [31:0] w_beat_addr;
    logic        w_stall;
    logic        w_abort;
    logic        w_last_wr;

`ifdef MEM_ARB_RR_EN
    logic        r_last_data;  // 1 = data port was granted last
`endif

    assign w_if_ok     = bus.if_req && !bus.if_flush;
    assign w_beat_addr = r_addr + {29'd0, r_cnt};
    assign w_stall     = (r_state == C_WR) && (w_beat_addr[17:16] == 2'b11)
                         && bus.io_buffer_full;
    assign w_abort     = (r_state == C_RD) && !r_is_data && bus.if_flush;
    assign w_last_wr   = (r_cnt == (r_len - 3'd1));

    // Grant decision, only meaningful while idle
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (r_state == C_IDLE) begin
`ifdef MEM_ARB_RR_EN
            if (bus.d_req && w_if_ok) begin
                w_grant_d = !r_last_data;
                w_grant_i = r_last_data;
            end else begin
                w_grant_d = bus.d_req;
                w_grant_i = w_if_ok;
            end
`else
            w_grant_d = bus.d_req;
            w_grant_i = !bus.d_req && w_if_ok;
`endif
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember which port won the most recent grant
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_last_data <= 1'b0;
        end else if (rdy_in && (w_grant_d || w_grant_i)) begin
            r_last_data <= w_grant_d;
        end
    end
`endif

    // State register; rdy_in low holds the current state
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= C_IDLE;
        end else if (rdy_in) begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE: begin
                if (w_grant_d) begin
                    w_next_state = bus.d_wr ? C_WR : C_RD;
                end else if (w_grant_i) begin
                    w_next_state = C_RD;
                end
            end
            C_RD: begin
                if (w_abort) begin
                    w_next_state = C_IDLE;
                end else if (r_cnt == r_len) begin
                    w_next_state = C_DONE;
                end
            end
            C_WR: begin
                if (!w_stall && w_last_wr) begin
                    w_next_state = C_DONE;
                end
            end
            default: w_next_state = C_IDLE;
        endcase
    end

    // Transaction latch, beat counter and read-lane assembly
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt      <= 3'd0;
            r_len      <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_is_data  <= 1'b0;
            r_cap_en   <= 1'b0;
            r_cap_lane <= 2'd0;
            r_data     <= 32'd0;
        end else begin
            // A byte already requested is captured even while frozen
            if (r_cap_en) begin
                r_data[{r_cap_lane, 3'b000} +: 8] <= bus.mem_din;
            end
            r_cap_en <= 1'b0;
            if (rdy_in) begin
                case (r_state)
                    C_IDLE: begin
                        if (w_grant_d || w_grant_i) begin
                            r_cnt     <= 3'd0;
                            r_is_data <= w_grant_d;
                            r_addr    <= w_grant_d ? bus.d_addr : bus.if_addr;
                            r_wdata   <= bus.d_wdata;
                            r_data    <= 32'd0;
                            if (!w_grant_d || bus.d_size[1]) begin
                                r_len <= 3'd4;
                            end else if (bus.d_size[0]) begin
                                r_len <= 3'd2;
                            end else begin
                                r_len <= 3'd1;
                            end
                        end
                    end
                    C_RD: begin
                        if (w_abort) begin
                            r_data <= 32'd0;
                        end else if (r_cnt != r_len) begin
                            r_cap_en   <= 1'b1;
                            r_cap_lane <= r_cnt[1:0];
                            r_cnt      <= r_cnt + 3'd1;
                        end
                    end
                    C_WR: begin
                        if (!w_stall) begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bus and handshake outputs decoded from the current state
    always_comb begin
        bus.busy     = (r_state != C_IDLE);
        bus.d_done   = (r_state == C_DONE) && r_is_data;
        bus.if_done  = (r_state == C_DONE) && !r_is_data && !bus.if_flush;
        bus.mem_a    = 32'd0;
        bus.mem_dout = 8'd0;
        bus.mem_wr   = 1'b0;
        case (r_state)
            C_RD: begin
                // The trailing capture cycle issues no address
                if (r_cnt != r_len) begin
                    bus.mem_a = w_beat_addr;
                end
            end
            C_WR: begin
                bus.mem_a    = w_beat_addr;
                bus.mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                bus.mem_wr   = rdy_in && !w_stall;
            end
            default: ;
        endcase
    end

    assign bus.d_rdata = r_data;
    assign bus.if_data = r_data;

endmodule
`default_nettype wire
